mem_port_arbiter: RTL

Two-requester round-robin arbiter that shares the single data-memory port of the pipelined processor between instruction fetch (requester 0) and the load/store stage (requester 1). It sequences each access through a request/grant/done handshake and drives the select line of the 2:1 port mux that steers address and write data to memory. A watchdog counter aborts any access the memory fails to complete within a bounded number of cycles.

---
 rtl/mem_port_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the data-memory port between fetch (0) and load/store (1).
// Each access runs request -> grant/mem_start -> mem_done (or watchdog abort) -> done/err.
module mem_port_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       mem_done,
   output logic [1:0] grant,
   output logic       sel,
   output logic       mem_start,
   output logic [1:0] done,
   output logic [1:0] err,
   output logic [0:0] state_dbg
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   // Handshake: a requester holds req[i] until it sees done[i] or err[i]; grant is the
   // one-hot owner, mem_start pulses once per access, and mem_done closes it.
   logic [0:0]    state;
   logic          last;
   logic [CW-1:0] cnt;
   logic [1:0]    eff;
   logic          pick;

   // A requester is ignored in the cycle its own done/err pulse is showing.
   always_comb begin
      eff  = req & ~done & ~err;
      pick = (eff == 2'b11) ? ~last : eff[1];
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= 2'b00;
         sel       <= 1'b0;
         mem_start <= 1'b0;
         done      <= 2'b00;
         err       <= 2'b00;
         cnt       <= '0;
         last      <= 1'b1;
      end else begin
         mem_start <= 1'b0;
         done      <= 2'b00;
         err       <= 2'b00;
         case (state)
            IDLE: begin
               if (eff != 2'b00) begin
                  state     <= BUSY;
                  grant     <= pick ? 2'b10 : 2'b01;
                  sel       <= pick;
                  mem_start <= 1'b1;
                  cnt       <= '0;
               end
            end
            BUSY: begin
               // mem_done takes priority over a watchdog expiry in the same cycle.
               if (mem_done) begin
                  state <= IDLE;
                  grant <= 2'b00;
                  done  <= grant;
                  last  <= sel;
               end else if (cnt == LAST_CNT) begin
                  state <= IDLE;
                  grant <= 2'b00;
                  err   <= grant;
                  last  <= sel;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
